keypad_scan_encoder: RTL and testbench

- Input-side counterpart of the FND display path: scans the calculator's 4x4 key matrix, debounces presses and encodes each press into a 4-bit key code.
- Uses the same hex code space that the BCD-to-FND font decoder displays.
- Sits between the board keypad pins and the calculator control FSM; the FSM acknowledges each code with a valid/ack handshake.

---
 rtl/keypad_scan_encoder.sv | 149 ++++++++++++++
 tb/tb_keypad_scan_encoder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_encoder.sv
// keypad_scan_encoder: scans a 4x4 active-low key matrix, debounces presses and emits 4-bit key codes over valid/ack.
// Define KEYPAD_AUTOREPEAT_EN to re-issue a held key every REPEAT_CNT scan ticks.
module keypad_scan_encoder #(
   parameter int SCAN_DIV     = 100000,
   parameter int DEBOUNCE_CNT = 20,
   parameter int REPEAT_CNT   = 500
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [3:0] i_row,
   output logic [3:0] o_col,
   output logic [3:0] o_key,
   output logic       o_key_valid,
   input  logic       i_key_ack,
   output logic       o_overrun
);
   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CNT);
   localparam bit DB_ONE = DEBOUNCE_CNT == 1;
   // nibble {row, col} holds the code; row 0 is the least significant group
   localparam logic [63:0] KEY_MAP = {4'hD, 4'hF, 4'h0, 4'hE, 4'hC, 4'h9, 4'h8, 4'h7,
                                      4'hB, 4'h6, 4'h5, 4'h4, 4'hA, 4'h3, 4'h2, 4'h1};

   if (SCAN_DIV < 2 || DEBOUNCE_CNT < 1 || REPEAT_CNT < 1) begin : g_bad_param
      $error("keypad_scan_encoder: parameter out of range");
   end

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

   state_t        state_q, state_d;
   logic [3:0]    row_s1_q, row_s2_q, col_q, col_d, key_q, key_d, col_nx;
   logic [DW-1:0] div_q, div_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    row_l_q, row_l_d, col_l_q, col_l_d, row_idx, col_idx;
   logic          valid_q, valid_d, ovr_q, ovr_d, tick, hit, row_up, issue, rpt;

   assign tick    = div_q == DIV_MAX;
   assign hit     = row_s2_q inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
   assign row_idx = !row_s2_q[0] ? 2'd0 : !row_s2_q[1] ? 2'd1 : !row_s2_q[2] ? 2'd2 : 2'd3;
   assign col_idx = !col_q[0] ? 2'd0 : !col_q[1] ? 2'd1 : !col_q[2] ? 2'd2 : 2'd3;
   assign row_up  = row_s2_q[row_l_q];
   assign col_nx  = {col_q[2:0], col_q[3]};

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int RW = $clog2(REPEAT_CNT + 1);
   localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CNT);
   logic [RW-1:0] rep_q, rep_d;
   always_comb begin
      rep_d = state_q == HELD ? rep_q : '0;
      rpt   = 1'b0;
      if (state_q == HELD && tick) begin
         rpt   = !row_up && rep_q + RW'(1) == REP_MAX;
         rep_d = (row_up || rpt) ? '0 : rep_q + RW'(1);
      end
   end
   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) rep_q <= '0;
      else rep_q <= rep_d;
`else
   assign rpt = 1'b0;
`endif

   always_comb begin
      div_d   = tick ? '0 : div_q + DW'(1);
      state_d = state_q;
      col_d   = col_q;
      row_l_d = row_l_q;
      col_l_d = col_l_q;
      cnt_d   = cnt_q;
      issue   = 1'b0;
      if (tick)
         case (state_q)
            SCAN:
               if (hit) begin
                  row_l_d = row_idx;
                  col_l_d = col_idx;
                  cnt_d   = CW'(1);
                  issue   = DB_ONE;
                  state_d = DB_ONE ? HELD : DEBOUNCE;
               end else col_d = col_nx;
            DEBOUNCE:
               if (hit && row_idx == row_l_q) begin
                  cnt_d   = cnt_q + CW'(1);
                  issue   = cnt_d == DB_MAX;
                  state_d = issue ? HELD : DEBOUNCE;
               end else begin
                  cnt_d   = '0;
                  state_d = SCAN;
               end
            HELD:
               if (row_up) begin
                  cnt_d   = CW'(1);
                  state_d = DB_ONE ? SCAN : RELEASE;
                  col_d   = DB_ONE ? col_nx : col_q;
               end
            default:
               if (row_up) begin
                  cnt_d   = cnt_q + CW'(1);
                  state_d = cnt_d == DB_MAX ? SCAN : RELEASE;
                  col_d   = cnt_d == DB_MAX ? col_nx : col_q;
               end else state_d = HELD;
         endcase
      key_d   = key_q;
      valid_d = valid_q && !i_key_ack;
      ovr_d   = ovr_q;
      // an un-acked code blocks the new one; an ack in the same cycle frees the slot
      if (issue || rpt) begin
         if (valid_q && !i_key_ack) ovr_d = 1'b1;
         else begin
            key_d   = KEY_MAP[{row_l_d, col_l_d, 2'b00} +: 4];
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) begin
         row_s1_q <= 4'hF;
         row_s2_q <= 4'hF;
         div_q    <= '0;
         state_q  <= SCAN;
         col_q    <= 4'b1110;
         row_l_q  <= '0;
         col_l_q  <= '0;
         cnt_q    <= '0;
         key_q    <= 4'h0;
         valid_q  <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         row_s1_q <= i_row;
         row_s2_q <= row_s1_q;
         div_q    <= div_d;
         state_q  <= state_d;
         col_q    <= col_d;
         row_l_q  <= row_l_d;
         col_l_q  <= col_l_d;
         cnt_q    <= cnt_d;
         key_q    <= key_d;
         valid_q  <= valid_d;
         ovr_q    <= ovr_d;
      end

   assign o_col       = col_q;
   assign o_key       = key_q;
   assign o_key_valid = valid_q;
   assign o_overrun   = ovr_q;
endmodule

// File: tb/tb_keypad_scan_encoder.sv
// tb_keypad_scan_encoder: keypad model drives rows from o_col; expected codes are queued and checked by a monitor.
module tb_keypad_scan_encoder;
   localparam int SCAN_DIV = 4, DB = 3, REP = 5;

   logic       clk = 1'b0, rst = 1'b1;
   logic [3:0] i_row, o_col, o_key;
   logic       o_key_valid, i_key_ack, o_overrun;
   logic       key_down = 1'b0, force_en = 1'b0, auto_ack = 1'b1, ack_man = 1'b0, pend = 1'b0;
   logic [1:0] key_r = 2'd0, key_c = 2'd0, tb_div;
   logic [3:0] force_val = 4'hF, mon_exp;
   logic [3:0] exp_q[$];
   int         checks = 0, errors = 0;

   always #5 clk = ~clk;

   // one pressed key pulls its row low only while its column is driven
   assign i_row = force_en ? force_val : (key_down && !o_col[key_c]) ? ~(4'b1 << key_r) : 4'hF;
   assign i_key_ack = auto_ack ? o_key_valid : ack_man;

   keypad_scan_encoder #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DB), .REPEAT_CNT(REP)) dut (
      .i_clk(clk), .i_reset(rst), .i_row(i_row), .o_col(o_col), .o_key(o_key),
      .o_key_valid(o_key_valid), .i_key_ack(i_key_ack), .o_overrun(o_overrun));

   always @(posedge clk or posedge rst)
      if (rst) tb_div <= 2'd0;
      else tb_div <= tb_div + 2'd1;

   always @(negedge clk) begin
      if (rst) pend = 1'b0;
      else begin
         if (o_key_valid && !pend) begin
            pend = 1'b1;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL key_unexpected: got %h, none expected", o_key);
            end else begin
               mon_exp = exp_q.pop_front();
               if (o_key !== mon_exp) begin
                  errors++;
                  $display("FAIL key_code: got %h expected %h", o_key, mon_exp);
               end
            end
         end
         if (o_key_valid && i_key_ack) pend = 1'b0;
      end
   end

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic to_tick;
      do begin
         @(posedge clk);
         #1;
      end while (tb_div != 2'd3);
   endtask

   task automatic press(input logic [1:0] r, input logic [1:0] c);
      int n;
      to_tick;
      key_r = r;
      key_c = c;
      key_down = 1'b1;
      n = 0;
      do begin
         to_tick;
         n++;
      end while (o_col != ~(4'b1 << c) && n < 16);
      chk("press_col", o_col, ~(4'b1 << c));
   endtask

   task automatic confirm;
      to_tick;
      to_tick;
      @(posedge clk);
      #1;
   endtask

   task automatic release_key;
      to_tick;
      key_down = 1'b0;
      repeat (3) to_tick;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] c;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_col", o_col, 4'b1110);
      chk("rst_key", o_key, 4'h0);
      chk("rst_valid", {3'b0, o_key_valid}, 4'h0);
      chk("rst_ovr", {3'b0, o_overrun}, 4'h0);
      rst = 1'b0;
      c = 4'b1110;
      repeat (5) begin
         to_tick;
         chk("rotate", o_col, c);
         c = {c[2:0], c[3]};
      end
      chk("idle_valid", {3'b0, o_key_valid}, 4'h0);
      // key 9: row 2, col 2
      exp_q.push_back(4'h9);
      press(2'd2, 2'd2);
      to_tick;
      to_tick;
      chk("lat_pre", {3'b0, o_key_valid}, 4'h0);
      @(posedge clk);
      #1;
      chk("lat_valid", {3'b0, o_key_valid}, 4'h1);
      chk("lat_key", o_key, 4'h9);
      @(posedge clk);
      #1;
      chk("ack_clear", {3'b0, o_key_valid}, 4'h0);
      // release 9 and press 0 (row 3, col 1) at once
      to_tick;
      key_r = 2'd3;
      key_c = 2'd1;
      exp_q.push_back(4'h0);
      for (int i = 0; i < 8; i++) begin
         to_tick;
         chk("early_valid", {3'b0, o_key_valid}, 4'h0);
      end
      @(posedge clk);
      #1;
      chk("key0_valid", {3'b0, o_key_valid}, 4'h1);
      chk("key0_code", o_key, 4'h0);
      // bounce: two hit ticks on key 1 then open
      release_key;
      press(2'd0, 2'd0);
      to_tick;
      key_down = 1'b0;
      to_tick;
      to_tick;
      chk("bounce_hold", o_col, 4'b1110);
      to_tick;
      chk("bounce_scan", o_col, 4'b1101);
      chk("bounce_valid", {3'b0, o_key_valid}, 4'h0);
      exp_q.push_back(4'hB);
      press(2'd1, 2'd3);
      confirm;
      // held 5: repeats only with the optional feature
      release_key;
      exp_q.push_back(4'h5);
`ifdef KEYPAD_AUTOREPEAT_EN
      exp_q.push_back(4'h5);
      exp_q.push_back(4'h5);
`endif
      press(2'd1, 2'd1);
      repeat (11) to_tick;
      release_key;
      // overrun: second confirmed key with no ack is dropped
      auto_ack = 1'b0;
      exp_q.push_back(4'h3);
      press(2'd0, 2'd2);
      confirm;
      chk("ovr_first_valid", {3'b0, o_key_valid}, 4'h1);
      release_key;
      press(2'd2, 2'd0);
      confirm;
      chk("ovr_key_kept", o_key, 4'h3);
      chk("ovr_set", {3'b0, o_overrun}, 4'h1);
      chk("ovr_valid", {3'b0, o_key_valid}, 4'h1);
      release_key;
      to_tick;
      chk("ovr_sticky", {3'b0, o_overrun}, 4'h1);
      // asynchronous reset while debouncing key 2
      press(2'd0, 2'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_col", o_col, 4'b1110);
      chk("arst_valid", {3'b0, o_key_valid}, 4'h0);
      chk("arst_ovr", {3'b0, o_overrun}, 4'h0);
      chk("arst_key", o_key, 4'h0);
      key_down = 1'b0;
      force_en = 1'b1;
      force_val = 4'b1001;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      // two rows low is not a hit: scanning continues
      c = 4'b1110;
      repeat (5) begin
         to_tick;
         chk("multi_row_col", o_col, c);
         c = {c[2:0], c[3]};
      end
      chk("multi_row_valid", {3'b0, o_key_valid}, 4'h0);
      force_en = 1'b0;
      // ack in the same cycle as a new issue
      exp_q.push_back(4'hA);
      press(2'd0, 2'd3);
      confirm;
      chk("a_valid", {3'b0, o_key_valid}, 4'h1);
      release_key;
      exp_q.push_back(4'h8);
      press(2'd2, 2'd1);
      to_tick;
      to_tick;
      ack_man = 1'b1;
      @(posedge clk);
      #1 ack_man = 1'b0;
      chk("same_valid", {3'b0, o_key_valid}, 4'h1);
      chk("same_key", o_key, 4'h8);
      chk("same_ovr", {3'b0, o_overrun}, 4'h0);
      ack_man = 1'b1;
      @(posedge clk);
      #1 ack_man = 1'b0;
      chk("final_ack", {3'b0, o_key_valid}, 4'h0);
      ack_man = 1'b1;
      repeat (2) @(posedge clk);
      #1 ack_man = 1'b0;
      chk("idle_ack_valid", {3'b0, o_key_valid}, 4'h0);
      chk("idle_ack_ovr", {3'b0, o_overrun}, 4'h0);
      release_key;
      repeat (3) to_tick;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_empty: got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
